scratchpad_dual_banked: RTL and testbench
=========================================

Name: scratchpad_dual_banked

Overview:
- Multi-bank, dual-port scratchpad; generalises the single-port scratchpad.
- Two independent request ports (A, B), each with a valid/ready request channel and a valid/ready response channel.
- Memory is NUM_BANKS banks of 64-bit rows, interleaved on doubleword address. A and B proceed in the same cycle on different banks; on a same-bank conflict they are arbitrated round-robin.
- Sits between core/accelerator load-store units and local memory.

Parameters:
NUM_BANKS, 4, bank count; power of 2, minimum 2
BANK_DEPTH, 256, 64-bit rows per bank; power of 2
SCRATCHPAD_BASE, 64'h0000_0000_8000_0000, byte base address; aligned to total size

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
a_req_valid  in  1  port A request valid
a_req_ready  out  1  port A request accepted this cycle when valid&ready
a_req_write  in  1  1=store, 0=load
a_req_addr  in  64  byte address
a_req_len  in  2  00 byte, 01 half, 10 word, 11 double
a_req_wdata  in  64  store data, right-aligned
a_rsp_valid  out  1  port A response valid
a_rsp_ready  in  1  port A response consumed
a_rsp_rdata  out  64  load data, zero-extended; 0 for stores/errors
a_rsp_err  out  1  out-of-range or misaligned
b_*  same set as a_*, port B
scrub_busy  out  1  high during post-reset scrub (see Optional Feature)

Behaviour:
- Address decode:
  - SIZE = NUM_BANKS*BANK_DEPTH*8 bytes; off = addr - SCRATCHPAD_BASE.
  - bank = off[3 +: log2(NUM_BANKS)].
  - row = off[3+log2(NUM_BANKS) +: log2(BANK_DEPTH)].
  - lane = off[2:0].
- Error request (no memory access, rsp_err=1, rdata=0):
  - addr < SCRATCHPAD_BASE;
  - off >= SIZE;
  - lane not a multiple of the access size (1/2/4/8 bytes).
  Error requests need no bank and never take part in arbitration.
- Store: writes the low 8*size bits of wdata into bytes lane..lane+size-1 of the row; all other bytes are unchanged.
- Load: returns bytes lane..lane+size-1, right-aligned and zero-extended.
- x_req_ready = !rst && run_state && (!x_rsp_valid || x_rsp_ready) && (request is an error || x holds the grant for its bank).
  - Ready may depend combinationally on valid.
- Arbitration:
  - If A and B are both valid, both eligible, both non-error and target the same bank, only the port named by the prio flag is granted.
  - prio toggles after every conflict cycle.
  - prio resets to A.
  - Different banks: both ports are granted in the same cycle.
- Latency: the response is registered. rsp_valid rises the cycle after acceptance. rdata/err hold stable while rsp_valid && !rsp_ready.
- A new acceptance in the cycle a response drains gives back-to-back responses (1 per cycle per port).
- Same-cycle A store and B load to the same bank cannot occur (arbitrated). A load issued the cycle after a store to the same address returns the new data.
- Reset:
  - rsp_valid=0, rdata=0, rsp_err=0, prio=A, scrub_busy=0.
  - Any in-flight response is dropped.
  - Memory contents are not reset.
- Top-level FSM: SCRUB -> RUN. Without the macro, RUN is entered immediately out of reset.

Optional Feature:
- Macro: SCRATCHPAD_SCRUB_EN.
- Defined:
  - On reset deassertion the FSM enters SCRUB with scrub_busy=1 and both req_ready=0.
  - Each cycle it writes 0 to row r of every bank, with r counting 0..BANK_DEPTH-1.
  - After BANK_DEPTH cycles it enters RUN and scrub_busy drops.
  - Reset asserted mid-scrub restarts at row 0.
- Undefined: no scrub counter, scrub_busy tied 0, RUN straight after reset, memory contents undefined until written.

Test Plan:
1. A store double 0x1122334455667788 at 0x8000_0008, then A load double at the same address -> rsp 1 cycle after accept, rdata=0x1122334455667788, err=0.
2. A store byte 0xAB at 0x8000_0009, then B load double at 0x8000_0008 -> rdata=0x11223344_5566AB88. B load half at 0x8000_000E -> rdata=0x0000_0000_0000_1122.
3. A load 0x8000_0000 and B load 0x8000_0020 (both bank 0) issued together, twice -> round 1: A granted, B next cycle; round 2: B granted first.
4. A load 0x8000_0000 (bank 0) with B load 0x8000_0008 (bank 1) -> both ready the same cycle; both rsp_valid the next cycle.
5. Half load at 0x8000_0001, double at 0x8000_2000, double at 0x7FFF_FFF8 -> err=1, rdata=0 for each. A store double at 0x8000_2000 -> err=1; a subsequent load of 0x8000_0000 is unchanged.
6. Hold a_rsp_ready=0 for 3 cycles with a_req_valid=1 -> a_rsp held stable, a_req_ready=0. With SCRATCHPAD_SCRUB_EN: scrub_busy high for 256 cycles after reset, then any load returns 0.

Source files
------------

// File: rtl/scratchpad_dual_banked.sv
// Dual-port, multi-bank 64-bit scratchpad with round-robin arbitration on bank conflicts.
// Optional post-reset zeroing of all rows is enabled by defining SCRATCHPAD_SCRUB_EN.
module scratchpad_dual_banked #(
  parameter int          NUM_BANKS       = 4,
  parameter int          BANK_DEPTH      = 256,
  parameter logic [63:0] SCRATCHPAD_BASE = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic        a_req_write,
  input  logic [63:0] a_req_addr,
  input  logic [1:0]  a_req_len,
  input  logic [63:0] a_req_wdata,
  output logic        a_rsp_valid,
  input  logic        a_rsp_ready,
  output logic [63:0] a_rsp_rdata,
  output logic        a_rsp_err,
  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic        b_req_write,
  input  logic [63:0] b_req_addr,
  input  logic [1:0]  b_req_len,
  input  logic [63:0] b_req_wdata,
  output logic        b_rsp_valid,
  input  logic        b_rsp_ready,
  output logic [63:0] b_rsp_rdata,
  output logic        b_rsp_err,
  output logic        scrub_busy
);

  localparam int          LB   = $clog2(NUM_BANKS);
  localparam int          LR   = $clog2(BANK_DEPTH);
  localparam logic [63:0] SIZE = 64'(NUM_BANKS) * 64'(BANK_DEPTH) * 64'd8;

  typedef enum logic {ST_SCRUB, ST_RUN} state_t;

  state_t state, state_nxt;
  logic   run;
  logic   prio;  // 0 = A wins the next conflict, 1 = B

  function automatic logic [2:0] align_mask(input logic [1:0] len);
    case (len)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] size_be(input logic [1:0] len);
    case (len)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] be_to_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic req_error(input logic [63:0] addr, input logic [63:0] off,
                                     input logic [1:0] len);
    return (addr < SCRATCHPAD_BASE) || (off >= SIZE) || ((off[2:0] & align_mask(len)) != 3'b000);
  endfunction

  // Address decode: banks interleave on doubleword, lane selects the byte within a row
  logic [63:0]   a_off, b_off;
  logic [LB-1:0] a_bank, b_bank;
  logic [LR-1:0] a_row, b_row;
  logic [2:0]    a_lane, b_lane;
  logic          a_err, b_err;

  assign a_off  = a_req_addr - SCRATCHPAD_BASE;
  assign b_off  = b_req_addr - SCRATCHPAD_BASE;
  assign a_lane = a_off[2:0];
  assign b_lane = b_off[2:0];
  assign a_bank = a_off[3 +: LB];
  assign b_bank = b_off[3 +: LB];
  assign a_row  = a_off[3+LB +: LR];
  assign b_row  = b_off[3+LB +: LR];
  assign a_err  = req_error(a_req_addr, a_off, a_req_len);
  assign b_err  = req_error(b_req_addr, b_off, b_req_len);

  // Arbitration: only valid, non-error requests with response room compete for a bank
  logic a_room, b_room, a_elig, b_elig, conflict, a_grant, b_grant, a_acc, b_acc;

  assign run         = (state == ST_RUN) && !rst;
  assign a_room      = !a_rsp_valid || a_rsp_ready;
  assign b_room      = !b_rsp_valid || b_rsp_ready;
  assign a_elig      = run && a_req_valid && a_room && !a_err;
  assign b_elig      = run && b_req_valid && b_room && !b_err;
  assign conflict    = a_elig && b_elig && (a_bank == b_bank);
  assign a_grant     = a_elig && (!conflict || !prio);
  assign b_grant     = b_elig && (!conflict || prio);
  assign a_req_ready = run && a_room && (a_err || a_grant);
  assign b_req_ready = run && b_room && (b_err || b_grant);
  assign a_acc       = a_req_valid && a_req_ready;
  assign b_acc       = b_req_valid && b_req_ready;

  logic [63:0] a_wsh, b_wsh, a_bm, b_bm;
  assign a_wsh = a_req_wdata << {a_lane, 3'b000};
  assign b_wsh = b_req_wdata << {b_lane, 3'b000};
  assign a_bm  = be_to_mask(size_be(a_req_len) << a_lane);
  assign b_bm  = be_to_mask(size_be(b_req_len) << b_lane);

`ifdef SCRATCHPAD_SCRUB_EN
  logic [LR-1:0] scrub_row;
  localparam state_t RESET_STATE = ST_SCRUB;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  logic [63:0] a_rd_bank [NUM_BANKS];
  logic [63:0] b_rd_bank [NUM_BANKS];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [63:0] rows [BANK_DEPTH];
    logic        a_we, b_we;

    assign a_rd_bank[g] = rows[a_row];
    assign b_rd_bank[g] = rows[b_row];
    assign a_we = a_acc && a_req_write && !a_err && (a_bank == LB'(g));
    assign b_we = b_acc && b_req_write && !b_err && (b_bank == LB'(g));

    // Arbitration guarantees at most one port writes a bank per cycle
    always_ff @(posedge clk) begin
`ifdef SCRATCHPAD_SCRUB_EN
      if (scrub_busy)
        rows[scrub_row] <= '0;
      else
`endif
      if (a_we)
        rows[a_row] <= (a_rd_bank[g] & ~a_bm) | (a_wsh & a_bm);
      else if (b_we)
        rows[b_row] <= (b_rd_bank[g] & ~b_bm) | (b_wsh & b_bm);
    end
  end

  logic [63:0] a_load, b_load;
  assign a_load = (a_rd_bank[a_bank] >> {a_lane, 3'b000}) & be_to_mask(size_be(a_req_len));
  assign b_load = (b_rd_bank[b_bank] >> {b_lane, 3'b000}) & be_to_mask(size_be(b_req_len));

  // Response stage: one registered slot per port, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rsp_valid <= 1'b0;
      a_rsp_rdata <= '0;
      a_rsp_err   <= 1'b0;
      b_rsp_valid <= 1'b0;
      b_rsp_rdata <= '0;
      b_rsp_err   <= 1'b0;
      prio        <= 1'b0;
    end else begin
      if (a_acc) begin
        a_rsp_valid <= 1'b1;
        a_rsp_err   <= a_err;
        a_rsp_rdata <= (a_err || a_req_write) ? '0 : a_load;
      end else if (a_rsp_ready) begin
        a_rsp_valid <= 1'b0;
      end
      if (b_acc) begin
        b_rsp_valid <= 1'b1;
        b_rsp_err   <= b_err;
        b_rsp_rdata <= (b_err || b_req_write) ? '0 : b_load;
      end else if (b_rsp_ready) begin
        b_rsp_valid <= 1'b0;
      end
      if (conflict) prio <= ~prio;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef SCRATCHPAD_SCRUB_EN
    if (state == ST_SCRUB && scrub_row == LR'(BANK_DEPTH - 1)) state_nxt = ST_RUN;
`endif
  end

`ifdef SCRATCHPAD_SCRUB_EN
  assign scrub_busy = (state == ST_SCRUB) && !rst;

  always_ff @(posedge clk) begin
    if (rst)                    scrub_row <= '0;
    else if (state == ST_SCRUB) scrub_row <= scrub_row + LR'(1);
  end
`else
  assign scrub_busy = 1'b0;
`endif

endmodule

// File: tb/tb_scratchpad_dual_banked.sv
// Directed self-checking bench for scratchpad_dual_banked (default geometry 4 banks x 256 rows).
module tb_scratchpad_dual_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_rsp_ready = 1'b1;
  logic [63:0] a_req_addr = '0, a_req_wdata = '0;
  logic [1:0]  a_req_len = '0;
  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_rsp_ready = 1'b1;
  logic [63:0] b_req_addr = '0, b_req_wdata = '0;
  logic [1:0]  b_req_len = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, b_req_ready, b_rsp_valid, b_rsp_err, scrub_busy;
  logic [63:0] a_rsp_rdata, b_rsp_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scratchpad_dual_banked dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_len(a_req_len), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
    .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_len(b_req_len), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
    .b_rsp_err(b_rsp_err),
    .scrub_busy(scrub_busy)
  );

  // Single request on one port; returns the response sampled one cycle after acceptance
  task automatic do_req(input bit port, input bit wr, input logic [63:0] addr, input logic [1:0] len,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output logic vl, output int lat);
    @(negedge clk);
    if (!port) begin
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_len = len; a_req_wdata = wd;
    end else begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_len = len; b_req_wdata = wd;
    end
    lat = 0;
    #1;
    while (((!port && !a_req_ready) || (port && !b_req_ready)) && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    @(posedge clk);
    @(negedge clk);
    if (!port) a_req_valid = 1'b0; else b_req_valid = 1'b0;
    #1;
    if (!port) begin vl = a_rsp_valid; rd = a_rsp_rdata; er = a_rsp_err; end
    else       begin vl = b_rsp_valid; rd = b_rsp_rdata; er = b_rsp_err; end
  endtask

  task automatic wait_scrub_done();
`ifdef SCRATCHPAD_SCRUB_EN
    int n = 0;
    #1;
    while (scrub_busy && n < 1000) begin @(negedge clk); #1; n++; end
    tests++; if (n != 256) begin fails++; $display("FAIL scrub_cycles got %0d exp 256", n); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 64'h8000_0000; a_req_len = 2'b11;
    #1;
    tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_a_rsp_valid got %b exp 0", a_rsp_valid); end
    tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_b_rsp_valid got %b exp 0", b_rsp_valid); end
    tests++; if (a_rsp_rdata !== 64'h0) begin fails++; $display("FAIL rst_a_rdata got %h exp 0", a_rsp_rdata); end
    tests++; if (a_rsp_err !== 1'b0) begin fails++; $display("FAIL rst_a_err got %b exp 0", a_rsp_err); end
    tests++; if (scrub_busy !== 1'b0) begin fails++; $display("FAIL rst_scrub_busy got %b exp 0", scrub_busy); end
    tests++; if (a_req_ready !== 1'b0) begin fails++; $display("FAIL rst_a_ready got %b exp 0", a_req_ready); end
    a_req_valid = 1'b0;
    rst = 1'b0;
`ifdef SCRATCHPAD_SCRUB_EN
    wait_scrub_done();
`else
    #1;
    tests++; if (scrub_busy !== 1'b0) begin fails++; $display("FAIL run_scrub_busy got %b exp 0", scrub_busy); end
`endif
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er, vl; int lat;
    do_req(0, 1, 64'h8000_0008, 2'b11, 64'h1122_3344_5566_7788, rd, er, vl, lat);
    tests++; if (lat != 0) begin fails++; $display("FAIL t1_st_lat got %0d exp 0", lat); end
    tests++; if (vl !== 1'b1 || er !== 1'b0 || rd !== 64'h0) begin fails++; $display("FAIL t1_st_rsp got v%b e%b %h exp v1 e0 0", vl, er, rd); end
    do_req(0, 0, 64'h8000_0008, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (vl !== 1'b1 || er !== 1'b0) begin fails++; $display("FAIL t1_ld_rsp got v%b e%b exp v1 e0", vl, er); end
    tests++; if (rd !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL t1_ld_data got %h exp 1122334455667788", rd); end
  endtask

  task automatic test_byte_merge();
    logic [63:0] rd; logic er, vl; int lat;
    do_req(0, 1, 64'h8000_0009, 2'b00, 64'h0000_0000_0000_00AB, rd, er, vl, lat);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL t2_stb_err got %b exp 0", er); end
    do_req(1, 0, 64'h8000_0008, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (rd !== 64'h1122_3344_5566_AB88) begin fails++; $display("FAIL t2_ld_dbl got %h exp 112233445566AB88", rd); end
    do_req(1, 0, 64'h8000_000E, 2'b01, 64'h0, rd, er, vl, lat);
    tests++; if (rd !== 64'h0000_0000_0000_1122 || er !== 1'b0) begin fails++; $display("FAIL t2_ld_half got %h e%b exp 1122 e0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er, vl; int lat;
    do_req(0, 1, 64'h8000_0010, 2'b11, 64'h0, rd, er, vl, lat);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h8000_0014; a_req_len = 2'b10;
    a_req_wdata = 64'h0000_0000_DEAD_BEEF;
    #1;
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL b2b_st_ready got %b exp 1", a_req_ready); end
    @(posedge clk); @(negedge clk);
    a_req_write = 1'b0; a_req_addr = 64'h8000_0010; a_req_len = 2'b11;
    #1;
    tests++; if (a_rsp_valid !== 1'b1 || a_req_ready !== 1'b1) begin fails++; $display("FAIL b2b_overlap got v%b r%b exp v1 r1", a_rsp_valid, a_req_ready); end
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    tests++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'hDEAD_BEEF_0000_0000) begin fails++; $display("FAIL b2b_ld got v%b %h exp v1 DEADBEEF00000000", a_rsp_valid, a_rsp_rdata); end
  endtask

  task automatic test_conflict();
    logic [63:0] rd; logic er, vl; int lat;
    do_req(0, 1, 64'h8000_0000, 2'b11, 64'hCAFE_F00D_1234_5678, rd, er, vl, lat);
    do_req(1, 1, 64'h8000_0020, 2'b11, 64'h0123_4567_89AB_CDEF, rd, er, vl, lat);
    a_req_write = 1'b0; b_req_write = 1'b0; a_req_len = 2'b11; b_req_len = 2'b11;
    a_req_addr = 64'h8000_0000; b_req_addr = 64'h8000_0020;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      a_req_valid = 1'b1; b_req_valid = 1'b1;
      #1;
      tests++; if (a_req_ready !== (r == 0) || b_req_ready !== (r == 1)) begin fails++; $display("FAIL conf_r%0d_first got a%b b%b", r, a_req_ready, b_req_ready); end
      @(posedge clk); @(negedge clk);
      if (r == 0) a_req_valid = 1'b0; else b_req_valid = 1'b0;
      #1;
      tests++; if ((r == 0 ? b_req_ready : a_req_ready) !== 1'b1) begin fails++; $display("FAIL conf_r%0d_second_ready got 0 exp 1", r); end
      if (r == 0) begin
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'hCAFE_F00D_1234_5678) begin fails++; $display("FAIL conf_a_data got v%b %h exp v1 CAFEF00D12345678", a_rsp_valid, a_rsp_rdata); end
      end
      @(posedge clk); @(negedge clk);
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      #1;
      if (r == 0) begin
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL conf_b_data got v%b %h exp v1 0123456789ABCDEF", b_rsp_valid, b_rsp_rdata); end
      end else begin
        tests++; if (a_rsp_valid !== 1'b1) begin fails++; $display("FAIL conf_r1_a_rsp got %b exp 1", a_rsp_valid); end
      end
    end
  endtask

  task automatic test_parallel();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 64'h8000_0000; a_req_len = 2'b11;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 64'h8000_0008; b_req_len = 2'b11;
    #1;
    tests++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin fails++; $display("FAIL par_ready got a%b b%b exp a1 b1", a_req_ready, b_req_ready); end
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    #1;
    tests++; if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b1) begin fails++; $display("FAIL par_rsp got a%b b%b exp a1 b1", a_rsp_valid, b_rsp_valid); end
    tests++; if (a_rsp_rdata !== 64'hCAFE_F00D_1234_5678 || b_rsp_rdata !== 64'h1122_3344_5566_AB88) begin fails++; $display("FAIL par_data got a%h b%h", a_rsp_rdata, b_rsp_rdata); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er, vl; int lat;
    do_req(0, 0, 64'h8000_0001, 2'b01, 64'h0, rd, er, vl, lat);
    tests++; if (vl !== 1'b1 || er !== 1'b1 || rd !== 64'h0 || lat != 0) begin fails++; $display("FAIL err_misalign got v%b e%b %h lat%0d exp v1 e1 0 lat0", vl, er, rd, lat); end
    do_req(1, 0, 64'h8000_2000, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (er !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL err_above got e%b %h exp e1 0", er, rd); end
    do_req(0, 0, 64'h7FFF_FFF8, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (er !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL err_below got e%b %h exp e1 0", er, rd); end
    do_req(0, 1, 64'h8000_2000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, vl, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL err_store got e%b exp e1", er); end
    do_req(0, 0, 64'h8000_0000, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (er !== 1'b0 || rd !== 64'hCAFE_F00D_1234_5678) begin fails++; $display("FAIL err_nowrite got e%b %h exp e0 CAFEF00D12345678", er, rd); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 64'h8000_0008; a_req_len = 2'b11;
    #1;
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL stall_first_ready got %b exp 1", a_req_ready); end
    @(posedge clk);
    #1;
    a_req_addr = 64'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'h1122_3344_5566_AB88 || a_req_ready !== 1'b0) begin fails++; $display("FAIL stall_hold%0d got v%b %h r%b exp v1 112233445566AB88 r0", i, a_rsp_valid, a_rsp_rdata, a_req_ready); end
    end
    a_rsp_ready = 1'b1;
    #1;
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL stall_drain_ready got %b exp 1", a_req_ready); end
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    tests++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'hCAFE_F00D_1234_5678) begin fails++; $display("FAIL stall_next got v%b %h exp v1 CAFEF00D12345678", a_rsp_valid, a_rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er, vl; int lat;
    @(negedge clk);
    a_req_write = 1'b0; b_req_write = 1'b0; a_req_len = 2'b11; b_req_len = 2'b11;
    a_req_addr = 64'h8000_0000; b_req_addr = 64'h8000_0020;
    a_req_valid = 1'b1; b_req_valid = 1'b1; a_rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    tests++; if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 64'h0) begin fails++; $display("FAIL mid_rst_drop got v%b %h exp v0 0", a_rsp_valid, a_rsp_rdata); end
    rst = 1'b0; a_rsp_ready = 1'b1;
    wait_scrub_done();
    @(negedge clk);
    a_req_valid = 1'b1; b_req_valid = 1'b1;
    #1;
    tests++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_prio got a%b b%b exp a1 b0", a_req_ready, b_req_ready); end
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    b_req_valid = 1'b0;
`ifdef SCRATCHPAD_SCRUB_EN
    do_req(0, 0, 64'h8000_0000, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (rd !== 64'h0 || vl !== 1'b1) begin fails++; $display("FAIL scrub_zero got v%b %h exp v1 0", vl, rd); end
`else
    do_req(1, 0, 64'h8000_0008, 2'b11, 64'h0, rd, er, vl, lat);
    tests++; if (rd !== 64'h1122_3344_5566_AB88) begin fails++; $display("FAIL mid_rst_mem got %h exp 112233445566AB88", rd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_back_to_back();
    test_conflict();
    test_parallel();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
